// File: rtl/mul_share_pkg.sv
// Shared types and product-combine helpers for the shared 32x32 multiplier controller.
// The partial products come from four 16x16 multipliers; combine math lives here.
package mul_share_pkg;

    localparam int DATA_W = 32;
    localparam int PROD_W = 64;
    localparam int HALF_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        COMBINE,
        COMBINE2,
        RESP
    } state_t;

    // Widen one 32-bit partial product to 64 bits, sign-extending when its factors were signed.
    function automatic logic [PROD_W-1:0] ext64(input logic [DATA_W-1:0] p, input logic s);
        return s ? {{DATA_W{p[DATA_W-1]}}, p} : {{DATA_W{1'b0}}, p};
    endfunction

    function automatic logic [PROD_W-1:0] mul_combine(
        input logic [DATA_W-1:0] p1,
        input logic [DATA_W-1:0] p2,
        input logic [DATA_W-1:0] p3,
        input logic [DATA_W-1:0] p4,
        input logic              s1,
        input logic              s2
    );
        return {{DATA_W{1'b0}}, p1}
             + (ext64(p2, s2) << HALF_W)
             + (ext64(p3, s1) << HALF_W)
             + (ext64(p4, s1 | s2) << DATA_W);
    endfunction

endpackage

// File: rtl/mul_rr_arbiter.sv
// Combinational round-robin picker: first set request after i_last_grant, with wrap.
// The pointer register itself is owned by the parent.
module mul_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_en,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_valid
);

    int w_cand;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_valid     = 1'b0;
        w_cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = int'(i_last_grant) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (i_en && !o_valid && i_req[w_cand[IDX_W-1:0]]) begin
                o_valid     = 1'b1;
                o_grant_idx = w_cand[IDX_W-1:0];
            end
        end
        if (o_valid) begin
            o_grant[o_grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Time-shares one registered 32x32 multiplier cell between NUM_REQ requesters.
// Define MUL_SHARE_ARB_OUT_REG_EN to split the product combine over two cycles.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_src1,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_src2,
    input  logic [NUM_REQ-1:0]        i_req_src1_signed,
    input  logic [NUM_REQ-1:0]        i_req_src2_signed,
    input  logic [NUM_REQ-1:0]        i_req_high,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic [DATA_W-1:0]         o_rsp_data,
    output logic                      o_busy,
    output logic [DATA_W-1:0]         o_mc_src1,
    output logic [DATA_W-1:0]         o_mc_src2,
    output logic                      o_mc_src1_signed,
    output logic                      o_mc_src2_signed,
    output logic                      o_mc_en,
    input  logic [DATA_W-1:0]         i_mc_p1,
    input  logic [DATA_W-1:0]         i_mc_p2,
    input  logic [DATA_W-1:0]         i_mc_p3,
    input  logic [DATA_W-1:0]         i_mc_p4
);

    state_t               r_state;
    logic [IDX_W-1:0]     r_last_grant;
    logic [IDX_W-1:0]     r_gidx;
    logic                 r_high;
    logic [DATA_W-1:0]    r_mc_src1;
    logic [DATA_W-1:0]    r_mc_src2;
    logic                 r_mc_s1;
    logic                 r_mc_s2;
    logic                 r_mc_en;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_data;
`ifdef MUL_SHARE_ARB_OUT_REG_EN
    logic [PROD_W-1:0]    r_mid_a;
    logic [PROD_W-1:0]    r_mid_b;
`endif

    logic [NUM_REQ-1:0]   w_grant;
    logic [IDX_W-1:0]     w_gidx;
    logic                 w_gvalid;
    logic [PROD_W-1:0]    w_final;
    logic [DATA_W-1:0]    w_word;
    logic [NUM_REQ-1:0]   w_onehot;

    mul_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_req        (i_req_valid),
        .i_en         (r_state == IDLE),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_gidx),
        .o_valid      (w_gvalid)
    );

`ifdef MUL_SHARE_ARB_OUT_REG_EN
    assign w_final = r_mid_a + r_mid_b;
`else
    assign w_final = mul_combine(i_mc_p1, i_mc_p2, i_mc_p3, i_mc_p4, r_mc_s1, r_mc_s2);
`endif

    assign w_word   = r_high ? w_final[PROD_W-1:DATA_W] : w_final[DATA_W-1:0];
    assign w_onehot = NUM_REQ'(1) << r_gidx;

    assign o_req_ready      = w_grant;
    assign o_busy           = (r_state != IDLE);
    assign o_rsp_valid      = r_rsp_valid;
    assign o_rsp_data       = r_rsp_data;
    assign o_mc_src1        = r_mc_src1;
    assign o_mc_src2        = r_mc_src2;
    assign o_mc_src1_signed = r_mc_s1;
    assign o_mc_src2_signed = r_mc_s2;
    assign o_mc_en          = r_mc_en;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_gidx       <= '0;
            r_high       <= 1'b0;
            r_mc_src1    <= '0;
            r_mc_src2    <= '0;
            r_mc_s1      <= 1'b0;
            r_mc_s2      <= 1'b0;
            r_mc_en      <= 1'b0;
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
`ifdef MUL_SHARE_ARB_OUT_REG_EN
            r_mid_a      <= '0;
            r_mid_b      <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gvalid) begin
                        r_mc_src1    <= i_req_src1[w_gidx*DATA_W +: DATA_W];
                        r_mc_src2    <= i_req_src2[w_gidx*DATA_W +: DATA_W];
                        r_mc_s1      <= i_req_src1_signed[w_gidx];
                        r_mc_s2      <= i_req_src2_signed[w_gidx];
                        r_high       <= i_req_high[w_gidx];
                        r_gidx       <= w_gidx;
                        r_last_grant <= w_gidx;
                        r_mc_en      <= 1'b1;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The cell captures the operands at this edge and holds once M_en drops.
                    r_mc_en <= 1'b0;
                    r_state <= COMBINE;
                end
`ifdef MUL_SHARE_ARB_OUT_REG_EN
                COMBINE: begin
                    r_mid_a <= {{DATA_W{1'b0}}, i_mc_p1} + (ext64(i_mc_p2, r_mc_s2) << HALF_W);
                    r_mid_b <= (ext64(i_mc_p3, r_mc_s1) << HALF_W)
                             + (ext64(i_mc_p4, r_mc_s1 | r_mc_s2) << DATA_W);
                    r_state <= COMBINE2;
                end
                COMBINE2: begin
                    r_rsp_valid <= w_onehot;
                    r_rsp_data  <= w_word;
                    r_state     <= RESP;
                end
`else
                COMBINE: begin
                    r_rsp_valid <= w_onehot;
                    r_rsp_data  <= w_word;
                    r_state     <= RESP;
                end
`endif
                RESP: begin
                    r_rsp_valid <= '0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
